// File: rtl/column_move_sequencer_if.sv
// Cursor-protocol bundle between an automatic-move source and the game FSM side.
// The slave modport is the sequencer; the master modport is whoever drives its requests.
interface column_move_sequencer_if #(
    parameter int NUM_COLS = 7
);
    logic                start;
    logic                cancel;
    logic [2:0]          target_col;
    logic [2:0]          cur_col;
    logic [NUM_COLS-1:0] col_full;
    logic                move_left;
    logic                move_right;
    logic                move_made;
    logic                busy;
    logic [2:0]          sel_col;
    logic                done;
    logic                error;

    modport slave (
        input  start, cancel, target_col, cur_col, col_full,
        output move_left, move_right, move_made, busy, sel_col, done, error
    );

    modport master (
        output start, cancel, target_col, cur_col, col_full,
        input  move_left, move_right, move_made, busy, sel_col, done, error
    );
endinterface

// File: rtl/column_move_sequencer.sv
// Automatic Connect-4 move: pick the nearest open column to a target, walk the
// cursor there with left/right pulses using cur_col feedback, then drop.
module column_move_sequencer #(
    parameter int NUM_COLS   = 7,
    parameter int GAP_CYCLES = 4
) (
    input logic                    clk,
    input logic                    reset_n,
    column_move_sequencer_if.slave bus
);
    localparam int              CW        = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int              GW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [2:0]      LAST_COL  = 3'(NUM_COLS - 1);
    localparam logic [3:0]      MAX_STEPS = 4'(NUM_COLS);
    localparam logic [GW-1:0]   GAP_LAST  = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SELECT, STEP, GAP, DROP, FINISH} state_t;

    state_t        state, nxt;
    logic [2:0]    tgt_q;
    logic [3:0]    step_cnt;
    logic [GW-1:0] gap_cnt;
    logic          found;
    logic [2:0]    pick, dest;
    logic          want_l, want_r, decide;
    logic          go_left, go_right, err;
    logic          move_left_d, move_right_d, move_made_d, busy_d, done_d, error_d;

    // Nearest open column; at equal distance the right-hand candidate wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int d = 0; d < NUM_COLS; d++) begin
            if (!found && (int'(tgt_q) + d < NUM_COLS) && !bus.col_full[CW'(int'(tgt_q) + d)]) begin
                found = 1'b1;
                pick  = 3'(int'(tgt_q) + d);
            end
            if (!found && (int'(tgt_q) >= d) && !bus.col_full[CW'(int'(tgt_q) - d)]) begin
                found = 1'b1;
                pick  = 3'(int'(tgt_q) - d);
            end
        end
    end

    // The step decision is taken on the edge into STEP so the pulse is
    // registered and visible during the STEP cycle itself.
    always_comb begin
        nxt      = state;
        go_left  = 1'b0;
        go_right = 1'b0;
        err      = 1'b0;
        dest     = (state == SELECT) ? pick : bus.sel_col;
        want_r   = bus.cur_col < dest;
        want_l   = bus.cur_col > dest;
        decide   = 1'b0;
        case (state)
            IDLE:    if (bus.start && !bus.cancel) nxt = SELECT;
            SELECT:  if (found) decide = 1'b1;
                     else begin
                         nxt = IDLE;
                         err = 1'b1;
                     end
            GAP:     if (gap_cnt == GAP_LAST) decide = 1'b1;
            STEP:    nxt = (bus.move_left || bus.move_right) ? GAP : DROP;
            DROP:    nxt = FINISH;
            FINISH:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (decide) begin
            if ((want_l || want_r) && step_cnt == MAX_STEPS) begin
                nxt = IDLE;
                err = 1'b1;
            end else begin
                nxt      = STEP;
                go_left  = want_l;
                go_right = want_r;
            end
        end
        if (bus.cancel && state != IDLE) begin
            nxt      = IDLE;
            go_left  = 1'b0;
            go_right = 1'b0;
            err      = 1'b0;
        end
    end

    always_comb begin
        move_left_d  = go_left;
        move_right_d = go_right;
        move_made_d  = (nxt == DROP);
        done_d       = (nxt == FINISH);
        error_d      = err;
        busy_d       = (nxt != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            bus.move_left  <= 1'b0;
            bus.move_right <= 1'b0;
            bus.move_made  <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.error      <= 1'b0;
            bus.sel_col    <= '0;
        end else begin
            state          <= nxt;
            bus.move_left  <= move_left_d;
            bus.move_right <= move_right_d;
            bus.move_made  <= move_made_d;
            bus.busy       <= busy_d;
            bus.done       <= done_d;
            bus.error      <= error_d;
            if (state == SELECT && nxt == STEP) bus.sel_col <= pick;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tgt_q    <= '0;
            step_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            if (state == IDLE && nxt == SELECT) begin
                tgt_q    <= (bus.target_col > LAST_COL) ? LAST_COL : bus.target_col;
                step_cnt <= '0;
            end else if (go_left || go_right) begin
                step_cnt <= step_cnt + 4'd1;
            end
            gap_cnt <= (state == GAP) ? gap_cnt + GW'(1) : '0;
        end
    end
endmodule
